// File: rtl/tick_timer_bank_if.sv
// tick_timer_bank_if: CPU load/readback bus for the timer channel bank.
// Master drives loads and read selects; slave returns registered read data.
interface tick_timer_bank_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_data,
    output rd_ch,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_data,
    input  rd_ch,
    output rd_data
  );
endinterface

// File: rtl/tick_timer_bank.sv
// tick_timer_bank: CPU/60 Hz tick dividers plus NUM_CH down-counting channels.
// Define TIMER_FRAC_EN for a phase-accumulator 60 Hz tick with exact mean rate.
module tick_timer_bank #(
  parameter int CLK_HZ  = 12000000,
  parameter int CPU_HZ  = 500,
  parameter int TICK_HZ = 60,
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 8,
  parameter int CH_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              timer_cpu_tick,
  output logic              timer_60hz_tick,
  tick_timer_bank_if.slave  bus,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] ch_expired
);

  localparam int CPU_DIV  = CLK_HZ / CPU_HZ;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CPU_CW   = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;

  if (CPU_DIV < 2) begin : g_cpu_div_err
    $error("tick_timer_bank: CPU_DIV must be >= 2");
  end
  if (TICK_DIV < 2) begin : g_tick_div_err
    $error("tick_timer_bank: TICK_DIV must be >= 2");
  end
  if (NUM_CH < 1 || (2 ** CH_W) < NUM_CH) begin : g_ch_err
    $error("tick_timer_bank: bad NUM_CH / CH_W");
  end

  logic [CPU_CW-1:0] cpu_cnt_q;
  logic [CPU_CW-1:0] cpu_cnt_d;
  logic              cpu_tick_q;
  logic              cpu_tick_d;
  logic              tick60_q;
  logic              tick60_d;

  logic [CNT_W-1:0]  ch_q [NUM_CH];
  logic [CNT_W-1:0]  ch_d [NUM_CH];
  logic [NUM_CH-1:0] exp_q;
  logic [NUM_CH-1:0] exp_d;
  logic [CNT_W-1:0]  rd_q;
  logic [CNT_W-1:0]  rd_d;

  always_comb begin
    cpu_cnt_d  = cpu_cnt_q;
    cpu_tick_d = 1'b0;
    if (enable) begin
      if (cpu_cnt_q == CPU_CW'(CPU_DIV - 1)) begin
        cpu_cnt_d  = '0;
        cpu_tick_d = 1'b1;
      end else begin
        cpu_cnt_d = cpu_cnt_q + CPU_CW'(1);
      end
    end
  end

`ifdef TIMER_FRAC_EN
  localparam int ACC_W = $clog2(CLK_HZ + TICK_HZ) + 1;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_sum;

  // Bresenham-style phase: ticks exactly TICK_HZ times per CLK_HZ cycles
  always_comb begin
    acc_sum  = acc_q + ACC_W'(TICK_HZ);
    acc_d    = acc_q;
    tick60_d = 1'b0;
    if (enable) begin
      if (acc_sum >= ACC_W'(CLK_HZ)) begin
        acc_d    = acc_sum - ACC_W'(CLK_HZ);
        tick60_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  localparam int TICK_CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [TICK_CW-1:0] t60_cnt_q;
  logic [TICK_CW-1:0] t60_cnt_d;

  always_comb begin
    t60_cnt_d = t60_cnt_q;
    tick60_d  = 1'b0;
    if (enable) begin
      if (t60_cnt_q == TICK_CW'(TICK_DIV - 1)) begin
        t60_cnt_d = '0;
        tick60_d  = 1'b1;
      end else begin
        t60_cnt_d = t60_cnt_q + TICK_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t60_cnt_q <= '0;
    end else begin
      t60_cnt_q <= t60_cnt_d;
    end
  end
`endif

  // A tick registered just before enable drops must not leak out
  assign timer_cpu_tick  = cpu_tick_q & enable;
  assign timer_60hz_tick = tick60_q & enable;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i]  = ch_q[i];
      exp_d[i] = 1'b0;
      if (bus.wr_en && bus.wr_ch == CH_W'(i)) begin
        ch_d[i] = bus.wr_data;
      end else if (timer_60hz_tick && ch_q[i] != '0) begin
        ch_d[i]  = ch_q[i] - CNT_W'(1);
        exp_d[i] = (ch_q[i] == CNT_W'(1));
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_W'(i)) begin
        rd_d = ch_q[i];
      end
    end
  end

  always_comb begin
    ch_active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_active[i] = |ch_q[i];
    end
  end

  assign ch_expired  = exp_q;
  assign bus.rd_data = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt_q  <= '0;
      cpu_tick_q <= 1'b0;
      tick60_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= '0;
      end
      exp_q <= '0;
      rd_q  <= '0;
    end else begin
      cpu_cnt_q  <= cpu_cnt_d;
      cpu_tick_q <= cpu_tick_d;
      tick60_q   <= tick60_d;
      ch_q       <= ch_d;
      exp_q      <= exp_d;
      rd_q       <= rd_d;
    end
  end

endmodule
